// File: rtl/shift_normalizer.sv
// Left-normalizes an operand by shifting out its leading zeros and reports the shift count.
// Latency: a result is valid on the accept edge when the MSB is already set or the operand is zero; otherwise it is valid k edges after accept, where k is the number of leading zeros.
// Backpressure: one operand in flight; in_ready is low from accept until the result is taken with out_ready.
module shift_normalizer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(WIDTH)-1:0] shift_out,
  output logic                     zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_shift;
  logic             r_zero;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_work_next;
  logic [CW-1:0]    w_cnt_inc;

  // Only zeros sit above the leading one, so a single-bit step never drops data.
  assign w_work_next = r_work << 1;
  assign w_cnt_inc   = r_cnt + CW'(1);

  // Gated with rst_n so a held reset never advertises readiness.
  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign out_valid = r_out_valid;
  assign data_out  = r_data;
  assign shift_out = r_shift;
  assign zero      = r_zero;

  // Control FSM plus working register; result registers load only when entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_shift     <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work <= data_in;
            r_cnt  <= '0;
            if (data_in == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_data      <= '0;
              r_shift     <= '0;
              r_zero      <= 1'b1;
            end else if (data_in[WIDTH-1]) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_data      <= data_in;
              r_shift     <= '0;
              r_zero      <= 1'b0;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_work_next;
          r_cnt  <= w_cnt_inc;
          if (w_work_next[WIDTH-1]) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_data      <= w_work_next;
            r_shift     <= w_cnt_inc;
            r_zero      <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
